instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the accumulator CPU: it owns the program counter (PC) and instruction register (IR). It fetches instructions from instruction memory over a request/acknowledge handshake and presents the opcode and immediate fields to the controller FSM. It also applies the controller's PC and IR controls (LoadPC, SelPC, IncPC, LoadIR) at the end of each execute cycle.

## Interface
Parameters:
- PC_WIDTH, 8: PC and memory address width.
- DATA_WIDTH, 8: register-file value width; the branch-to-register target uses RegVal[PC_WIDTH-1:0].
- RESET_PC, 0: PC value after reset.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- CLB  in  1  reset: one clock; reset is asynchronous and active-low.
- LoadPC  in  1  from controller; load a branch target into PC.
- SelPC  in  1  from controller; 1 selects immediate target, 0 selects register target.
- IncPC  in  1  from controller; PC+1.
- LoadIR  in  1  from controller; 0 requests halt.
- RegVal  in  DATA_WIDTH  register operand, used as branch target.
- MemReq  out  1  fetch request.
- MemAddr  out  PC_WIDTH  fetch address (equals PC).
- MemData  in  8  instruction word.
- MemAck  in  1  memory acknowledge.
- Opcode  out  4  to controller.
- Imm  out  4  IR[3:0], to datapath.
- PC  out  PC_WIDTH  current PC.
- InstrValid  out  1  high in EXEC.
- Halted  out  1  high in HALT.

## Operation
- Instruction format: IR[7:4] is the opcode; IR[3:0] is the immediate or register operand.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: entered from reset; goes to FETCH on the next posedge unconditionally.
- FETCH:
  - MemReq=1 and MemAddr=PC.
  - On a posedge with MemAck=1: IR<=MemData, then go to EXEC. Otherwise stay in FETCH.
- EXEC:
  - Opcode=IR[7:4] and InstrValid=1.
  - On the next posedge, control inputs are applied with this priority:
    - LoadIR=0: go to HALT, PC unchanged.
    - LoadPC=1: PC<=SelPC ? {zero-extended IR[3:0]} : RegVal[PC_WIDTH-1:0]; go to FETCH.
    - IncPC=1: PC<=PC+1, wrapping modulo 2^PC_WIDTH; go to FETCH.
    - No control asserted: PC unchanged; go to FETCH (re-fetches the same address).
- HALT: Halted=1, MemReq=0, and Opcode=IR[7:4] (1111) is held. The block exits HALT only through reset.
- Outside EXEC and HALT, Opcode is forced to 0000 (NOP) so the controller never re-executes a stale instruction. All control inputs are ignored outside EXEC.
- MemAck while MemReq=0 is ignored.

## Timing
- Reset values:
  - State=IDLE, PC=RESET_PC, IR=0.
  - MemReq=0, Opcode=0000, InstrValid=0, Halted=0.
  - MemAddr=RESET_PC, Imm=0.
- Reset asserted mid-fetch aborts the fetch: MemReq drops immediately (asynchronously) and any pending MemAck is discarded.
- Handshake:
  - MemReq rises on the posedge entering FETCH and stays high until the posedge on which MemAck=1 is sampled. It then falls in the same edge's update.
  - MemAddr is stable throughout FETCH.
  - MemData must be valid in the cycle MemAck is high.
- Controller interface:
  - Controller outputs change on negedge CLK; the fetch unit samples them on the following posedge.
  - EXEC lasts exactly one cycle. The controller therefore sees Opcode half a cycle after the EXEC entry edge.
- Throughput: one instruction per (FETCH cycles + 1). With zero-wait memory (MemAck high in the first FETCH cycle), that is 2 cycles per instruction.
- Branch targets are sampled at the EXEC exit posedge. RegVal must be stable at that edge.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OP_NOP=4'b0000, OP_HALT=4'b1111, branch opcodes).
  - instruction field positions (OPC_MSB/LSB, IMM_MSB/LSB).
  - fetch state enumeration.
- One sub-module, `pc_next`: combinational next-PC mux (priority LoadPC > IncPC > hold, with the wrap rule).
- The FSM, IR and handshake logic stay in instr_fetch_unit.

## Test plan
- Reset then zero-wait memory returning 8'h15 at address 0 → MemReq high at cycle 1, Opcode=0001 and Imm=5 in EXEC, then IncPC gives the next fetch at MemAddr=1.
- MemAck delayed 3 cycles → MemReq and MemAddr held for 3 cycles, Opcode=0000 throughout FETCH, IR loaded only on the ack edge.
- EXEC with LoadPC=1, SelPC=1, IR=8'h7A → next MemAddr=8'h0A. With SelPC=0 and RegVal=8'h3C → next MemAddr=8'h3C.
- PC=8'hFF with IncPC=1 → next MemAddr=8'h00.
- Instruction 8'hF0 (controller drives LoadIR=0, IncPC=0) → Halted=1, MemReq stays 0 for 20 cycles, PC frozen. Asserting CLB low then returns to IDLE with PC=RESET_PC.
- CLB pulsed low while MemReq=1 and MemAck arrives during reset → MemReq=0 immediately, IR unchanged (0), fetch restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: instruction field layout,
// opcode constants and the fetch-stage state enumeration.
package cpu_pkg;

    // Instruction word layout: opcode in the upper nibble, operand below.
    localparam int INSTR_WIDTH = 8;
    localparam int OPC_MSB     = 7;
    localparam int OPC_LSB     = 4;
    localparam int IMM_MSB     = 3;
    localparam int IMM_LSB     = 0;
    localparam int OPC_WIDTH   = OPC_MSB - OPC_LSB + 1;
    localparam int IMM_WIDTH   = IMM_MSB - IMM_LSB + 1;

    // Opcodes the fetch stage and controller agree on.
    localparam logic [OPC_WIDTH-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPC_WIDTH-1:0] OP_LDI  = 4'b0001;
    localparam logic [OPC_WIDTH-1:0] OP_JMPI = 4'b1000;  // branch to immediate
    localparam logic [OPC_WIDTH-1:0] OP_JMPR = 4'b1001;  // branch to register value
    localparam logic [OPC_WIDTH-1:0] OP_JZI  = 4'b1010;  // conditional, immediate target
    localparam logic [OPC_WIDTH-1:0] OP_JZR  = 4'b1011;  // conditional, register target
    localparam logic [OPC_WIDTH-1:0] OP_HALT = 4'b1111;

    // Fetch stage states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_t;

    // Extract the opcode field of an instruction word.
    function automatic logic [OPC_WIDTH-1:0] instr_opcode(input logic [INSTR_WIDTH-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    // Extract the immediate / register operand field of an instruction word.
    function automatic logic [IMM_WIDTH-1:0] instr_imm(input logic [INSTR_WIDTH-1:0] instr);
        return instr[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: branch load beats increment, increment
// beats hold. The increment wraps naturally at 2^PC_WIDTH.
module pc_next #(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                load_pc,
    input  logic                sel_pc,
    input  logic                inc_pc,
    input  logic [3:0]          imm,
    input  logic [PC_WIDTH-1:0] reg_target,
    output logic [PC_WIDTH-1:0] pc_nxt
);

    // Priority mux: LoadPC (immediate or register target) > IncPC > hold.
    always_comb begin
        pc_nxt = pc;
        if (load_pc) begin
            pc_nxt = sel_pc ? PC_WIDTH'(imm) : reg_target;
        end else if (inc_pc) begin
            pc_nxt = pc + PC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches over a req/ack handshake,
// presents opcode/immediate to the controller and applies its PC/IR controls
// on the edge that leaves EXEC.
module instr_fetch_unit #(
    parameter int                   PC_WIDTH   = 8,
    parameter int                   DATA_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  CLB,
    input  logic                  LoadPC,
    input  logic                  SelPC,
    input  logic                  IncPC,
    input  logic                  LoadIR,
    input  logic [DATA_WIDTH-1:0] RegVal,
    output logic                  MemReq,
    output logic [PC_WIDTH-1:0]   MemAddr,
    input  logic [7:0]            MemData,
    input  logic                  MemAck,
    output logic [3:0]            Opcode,
    output logic [3:0]            Imm,
    output logic [PC_WIDTH-1:0]   PC,
    output logic                  InstrValid,
    output logic                  Halted
);

    import cpu_pkg::*;

    fetch_state_t               state_reg;
    logic [PC_WIDTH-1:0]        pc_reg;
    logic [INSTR_WIDTH-1:0]     ir_reg;
    logic                       mem_req_reg;
    logic [OPC_WIDTH-1:0]       opcode_reg;
    logic                       instr_valid_reg;
    logic                       halted_reg;
    logic [PC_WIDTH-1:0]        pc_nxt;
    logic [PC_WIDTH-1:0]        reg_target;

    // Register-branch target is the low PC_WIDTH bits of the register operand.
    assign reg_target = RegVal[PC_WIDTH-1:0];

    pc_next #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc         (pc_reg),
        .load_pc    (LoadPC),
        .sel_pc     (SelPC),
        .inc_pc     (IncPC),
        .imm        (instr_imm(ir_reg)),
        .reg_target (reg_target),
        .pc_nxt     (pc_nxt)
    );

    // Fetch FSM with registered handshake and controller-facing outputs.
    // Opcode is loaded alongside IR so it is valid in the same cycle EXEC is
    // entered, and is forced to NOP whenever the unit falls back to FETCH.
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            ir_reg          <= '0;
            mem_req_reg     <= 1'b0;
            opcode_reg      <= OP_NOP;
            instr_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg   <= ST_FETCH;
                    mem_req_reg <= 1'b1;
                end
                ST_FETCH: begin
                    // MemReq is always high here, so an ack is always legal.
                    if (MemAck) begin
                        ir_reg          <= MemData;
                        opcode_reg      <= instr_opcode(MemData);
                        mem_req_reg     <= 1'b0;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    instr_valid_reg <= 1'b0;
                    if (!LoadIR) begin
                        // Halt keeps PC and leaves the opcode visible.
                        halted_reg <= 1'b1;
                        state_reg  <= ST_HALT;
                    end else begin
                        pc_reg      <= pc_nxt;
                        opcode_reg  <= OP_NOP;
                        mem_req_reg <= 1'b1;
                        state_reg   <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    // Only reset leaves HALT; everything is held.
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemReq     = mem_req_reg;
    assign MemAddr    = pc_reg;
    assign PC         = pc_reg;
    assign Opcode     = opcode_reg;
    assign Imm        = instr_imm(ir_reg);
    assign InstrValid = instr_valid_reg;
    assign Halted     = halted_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random
// instruction stream checked against a PC/IR model kept in the bench.
module tb_instr_fetch_unit;

    localparam logic [7:0] RST_PC = 8'h00;

    logic       clk;
    logic       clb;
    logic       load_pc, sel_pc, inc_pc, load_ir;
    logic [7:0] reg_val;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_ack;
    logic [3:0] opcode;
    logic [3:0] imm;
    logic [7:0] pc;
    logic       instr_valid;
    logic       halted;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_pc;

    instr_fetch_unit #(
        .PC_WIDTH   (8),
        .DATA_WIDTH (8),
        .RESET_PC   (RST_PC)
    ) dut (
        .CLK        (clk),
        .CLB        (clb),
        .LoadPC     (load_pc),
        .SelPC      (sel_pc),
        .IncPC      (inc_pc),
        .LoadIR     (load_ir),
        .RegVal     (reg_val),
        .MemReq     (mem_req),
        .MemAddr    (mem_addr),
        .MemData    (mem_data),
        .MemAck     (mem_ack),
        .Opcode     (opcode),
        .Imm        (imm),
        .PC         (pc),
        .InstrValid (instr_valid),
        .Halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rule for the PC after an EXEC cycle.
    function automatic logic [7:0] model_pc(input logic [7:0] cur, input bit lp, input bit sp,
                                            input bit ip, input bit li, input logic [7:0] instr,
                                            input logic [7:0] rv);
        int nxt;
        nxt = int'(cur);
        if (li) begin
            if (lp)      nxt = sp ? int'(instr % 16) : int'(rv);
            else if (ip) nxt = (int'(cur) + 1) % 256;
        end
        return 8'(nxt);
    endfunction

    // Controls outside EXEC must be ignored, so scramble them there.
    task automatic junk_controls();
        load_pc = 1'($urandom);
        sel_pc  = 1'($urandom);
        inc_pc  = 1'($urandom);
        load_ir = 1'($urandom);
        reg_val = 8'($urandom);
    endtask

    // Act as memory: start at a negedge in FETCH, stall wait_n cycles, then ack.
    // Returns the address seen and the number of cycles the request misbehaved.
    task automatic serve_fetch(input int wait_n, input logic [7:0] data,
                               output logic [7:0] addr_seen, output int hold_bad);
        logic [3:0] imm0;
        addr_seen = mem_addr;
        imm0      = imm;
        hold_bad  = 0;
        if (mem_req !== 1'b1 || opcode !== 4'h0) hold_bad++;
        for (int i = 0; i < wait_n; i++) begin
            mem_ack  = 1'b0;
            mem_data = 8'($urandom);
            junk_controls();
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== addr_seen || opcode !== 4'h0 ||
                instr_valid !== 1'b0 || imm !== imm0) hold_bad++;
        end
        mem_ack  = 1'b1;
        mem_data = data;
        junk_controls();
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = 8'($urandom);
    endtask

    // Act as controller for one EXEC cycle; capture what EXEC presented.
    task automatic exec_step(input bit lp, input bit sp, input bit ip, input bit li,
                             input logic [7:0] rv, output logic [3:0] opc, output logic [3:0] im,
                             output logic valid, output logic req);
        opc     = opcode;
        im      = imm;
        valid   = instr_valid;
        req     = mem_req;
        load_pc = lp;
        sel_pc  = sp;
        inc_pc  = ip;
        load_ir = li;
        reg_val = rv;
        @(negedge clk);
        junk_controls();
    endtask

    task automatic test_reset();
        clb     = 1'b0;
        mem_ack = 1'b0;
        mem_data = 8'h00;
        junk_controls();
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, opcode, instr_valid, halted, mem_addr, imm, pc} !== {1'b0, 4'h0, 1'b0, 1'b0, RST_PC, 4'h0, RST_PC})
            $display("FAIL reset_values: got req=%b opc=%h v=%b h=%b addr=%h imm=%h pc=%h expected 0/0/0/0/%h/0/%h",
                     mem_req, opcode, instr_valid, halted, mem_addr, imm, pc, RST_PC, RST_PC);
        else passed++;
        clb = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) $display("FAIL idle_no_req: got MemReq=%b expected 0", mem_req);
        else passed++;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RST_PC)
            $display("FAIL first_fetch: got req=%b addr=%h expected 1/%h", mem_req, mem_addr, RST_PC);
        else passed++;
        exp_pc = RST_PC;
    endtask

    task automatic test_zero_wait();
        logic [7:0] a; int bad; logic [3:0] o, i; logic v, r;
        serve_fetch(0, 8'h15, a, bad);
        checks++;
        if (a !== exp_pc || bad !== 0) $display("FAIL zw_fetch: got addr=%h bad=%0d expected %h/0", a, bad, exp_pc);
        else passed++;
        exec_step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, o, i, v, r);
        checks++;
        if ({o, i, v, r} !== {4'h1, 4'h5, 1'b1, 1'b0})
            $display("FAIL zw_exec: got opc=%h imm=%h v=%b req=%b expected 1/5/1/0", o, i, v, r);
        else passed++;
        exp_pc = model_pc(exp_pc, 1'b0, 1'b0, 1'b1, 1'b1, 8'h15, 8'h55);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc || instr_valid !== 1'b0 || opcode !== 4'h0)
            $display("FAIL zw_next: got req=%b addr=%h v=%b opc=%h expected 1/%h/0/0",
                     mem_req, mem_addr, instr_valid, opcode, exp_pc);
        else passed++;
    endtask

    task automatic test_delayed_ack();
        logic [7:0] a; int bad; logic [3:0] o, i; logic v, r;
        serve_fetch(3, 8'h2C, a, bad);
        checks++;
        if (a !== exp_pc || bad !== 0) $display("FAIL delay_hold: got addr=%h bad=%0d expected %h/0", a, bad, exp_pc);
        else passed++;
        exec_step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, o, i, v, r);
        checks++;
        if ({o, i, v} !== {4'h2, 4'hC, 1'b1}) $display("FAIL delay_exec: got opc=%h imm=%h v=%b expected 2/c/1", o, i, v);
        else passed++;
        exp_pc = model_pc(exp_pc, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2C, 8'h00);
    endtask

    task automatic test_branches();
        logic [7:0] a; int bad; logic [3:0] o, i; logic v, r;
        serve_fetch(1, 8'h7A, a, bad);
        exec_step(1'b1, 1'b1, 1'($urandom), 1'b1, 8'($urandom), o, i, v, r);
        exp_pc = model_pc(exp_pc, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7A, 8'h00);
        checks++;
        if (mem_addr !== 8'h0A || mem_addr !== exp_pc) $display("FAIL branch_imm: got addr=%h expected 0a", mem_addr);
        else passed++;
        serve_fetch(0, 8'h93, a, bad);
        exec_step(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, o, i, v, r);
        exp_pc = model_pc(exp_pc, 1'b1, 1'b0, 1'b1, 1'b1, 8'h93, 8'h3C);
        checks++;
        if (mem_addr !== 8'h3C || mem_addr !== exp_pc) $display("FAIL branch_reg: got addr=%h expected 3c", mem_addr);
        else passed++;
    endtask

    task automatic test_wrap_and_hold();
        logic [7:0] a; int bad; logic [3:0] o, i; logic v, r;
        serve_fetch(0, 8'h9F, a, bad);
        exec_step(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, o, i, v, r);
        exp_pc = model_pc(exp_pc, 1'b1, 1'b0, 1'b0, 1'b1, 8'h9F, 8'hFF);
        serve_fetch(2, 8'h40, a, bad);
        checks++;
        if (a !== 8'hFF || bad !== 0) $display("FAIL wrap_setup: got addr=%h bad=%0d expected ff/0", a, bad);
        else passed++;
        exec_step(1'b0, 1'b1, 1'b1, 1'b1, 8'h12, o, i, v, r);
        exp_pc = model_pc(exp_pc, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h12);
        checks++;
        if (mem_addr !== 8'h00 || mem_addr !== exp_pc) $display("FAIL pc_wrap: got addr=%h expected 00", mem_addr);
        else passed++;
        serve_fetch(0, 8'h5E, a, bad);
        exec_step(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, o, i, v, r);
        checks++;
        if (mem_addr !== exp_pc || mem_req !== 1'b1)
            $display("FAIL no_control_refetch: got addr=%h req=%b expected %h/1", mem_addr, mem_req, exp_pc);
        else passed++;
    endtask

    task automatic test_random_stream();
        logic [7:0] a, d, rv; int bad, w; bit lp, sp, ip; logic [3:0] o, i; logic v, r;
        for (int n = 0; n < 40; n++) begin
            w  = int'($urandom_range(0, 3));
            d  = 8'($urandom);
            rv = 8'($urandom);
            lp = 1'($urandom);
            sp = 1'($urandom);
            ip = 1'($urandom);
            serve_fetch(w, d, a, bad);
            checks++;
            if (a !== exp_pc || bad !== 0)
                $display("FAIL rand_fetch[%0d]: got addr=%h bad=%0d expected %h/0", n, a, bad, exp_pc);
            else passed++;
            exec_step(lp, sp, ip, 1'b1, rv, o, i, v, r);
            checks++;
            if ({o, i, v, r} !== {d[7:4], d[3:0], 1'b1, 1'b0})
                $display("FAIL rand_exec[%0d]: got opc=%h imm=%h v=%b req=%b expected %h/%h/1/0",
                         n, o, i, v, r, d[7:4], d[3:0]);
            else passed++;
            exp_pc = model_pc(exp_pc, lp, sp, ip, 1'b1, d, rv);
        end
        checks++;
        if (mem_addr !== exp_pc || mem_req !== 1'b1)
            $display("FAIL rand_final: got addr=%h req=%b expected %h/1", mem_addr, mem_req, exp_pc);
        else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        // Entered at a negedge in FETCH with a non-zero IR from earlier traffic.
        mem_ack = 1'b0;
        @(negedge clk);
        #2;
        clb = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) $display("FAIL async_req_drop: got MemReq=%b expected 0", mem_req);
        else passed++;
        mem_ack  = 1'b1;
        mem_data = 8'hAB;
        @(posedge clk);
        #1;
        checks++;
        if ({imm, opcode, pc, instr_valid} !== {4'h0, 4'h0, RST_PC, 1'b0})
            $display("FAIL ack_in_reset: got imm=%h opc=%h pc=%h v=%b expected 0/0/%h/0", imm, opcode, pc, instr_valid, RST_PC);
        else passed++;
        @(negedge clk);
        clb     = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RST_PC || imm !== 4'h0)
            $display("FAIL restart_fetch: got req=%b addr=%h imm=%h expected 1/%h/0", mem_req, mem_addr, imm, RST_PC);
        else passed++;
        exp_pc = RST_PC;
    endtask

    task automatic test_halt();
        logic [7:0] a; int bad; logic [3:0] o, i; logic v, r; logic [7:0] frozen;
        serve_fetch(1, 8'h12, a, bad);
        exec_step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, o, i, v, r);
        exp_pc = model_pc(exp_pc, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h00);
        serve_fetch(0, 8'hF0, a, bad);
        exec_step(1'b1, 1'b1, 1'b0, 1'b0, 8'h44, o, i, v, r);
        exp_pc = model_pc(exp_pc, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h44);
        frozen = exp_pc;
        checks++;
        if (o !== 4'hF || halted !== 1'b1)
            $display("FAIL halt_entry: got opc=%h halted=%b expected f/1", o, halted);
        else passed++;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            mem_ack  = 1'($urandom);
            mem_data = 8'($urandom);
            junk_controls();
            @(negedge clk);
            if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== frozen || opcode !== 4'hF || instr_valid !== 1'b0) bad++;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad !== 0) $display("FAIL halt_hold: got %0d bad cycles expected 0", bad);
        else passed++;
        clb = 1'b0;
        #1;
        checks++;
        if ({halted, pc, mem_req, opcode} !== {1'b0, RST_PC, 1'b0, 4'h0})
            $display("FAIL halt_reset: got halted=%b pc=%h req=%b opc=%h expected 0/%h/0/0", halted, pc, mem_req, opcode, RST_PC);
        else passed++;
        @(negedge clk);
        clb = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RST_PC)
            $display("FAIL post_halt_fetch: got req=%b addr=%h expected 1/%h", mem_req, mem_addr, RST_PC);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_branches();
        test_wrap_and_hold();
        test_random_stream();
        test_reset_mid_fetch();
        test_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
